// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch stage: program counter, instruction-memory address,
// IF/ID pipeline register and redirect resolution (B, CB and BR).
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        br_taken,
    input  logic        br_uncond,
    input  logic [31:0] br_instr,
    input  logic [63:0] br_pc,
    input  logic        br_reg,
    input  logic [63:0] br_reg_target,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    output logic        if_valid
);

    logic [63:0] pc_r;
    logic [31:0] if_instr_r;
    logic [63:0] if_pc_r;
    logic        if_valid_r;

    logic [63:0] offset_s;
    logic [63:0] rel_target_s;
    logic [63:0] reg_target_s;
    logic [63:0] pc_next_s;
    logic [31:0] if_instr_next_s;
    logic [63:0] if_pc_next_s;
    logic        if_valid_next_s;

    // Sign-extended, word-scaled branch offset for B (26-bit) or CB (19-bit) forms.
    always_comb begin
        offset_s = 64'h0;
        if (br_uncond) begin
            offset_s = {{36{br_instr[25]}}, br_instr[25:0], 2'b00};
        end else begin
            offset_s = {{43{br_instr[23]}}, br_instr[23:5], 2'b00};
        end
    end

    // Redirect targets: PC-relative sum wraps mod 2^64; register target is word-aligned.
    always_comb begin
        rel_target_s = br_pc + offset_s;
        reg_target_s = {br_reg_target[63:2], 2'b00};
    end

    // Next-state selection: BR beats B/CB, any redirect beats stall, else sequential fetch.
    always_comb begin
        pc_next_s       = pc_r;
        if_instr_next_s = if_instr_r;
        if_pc_next_s    = if_pc_r;
        if_valid_next_s = if_valid_r;
        if (br_reg) begin
            pc_next_s       = reg_target_s;
            if_instr_next_s = 32'h0;
            if_valid_next_s = 1'b0;
        end else if (br_taken) begin
            pc_next_s       = rel_target_s;
            if_instr_next_s = 32'h0;
            if_valid_next_s = 1'b0;
        end else if (stall) begin
            pc_next_s       = pc_r;
            if_instr_next_s = if_instr_r;
            if_pc_next_s    = if_pc_r;
            if_valid_next_s = if_valid_r;
        end else begin
            pc_next_s       = pc_r + 64'd4;
            if_instr_next_s = imem_rdata;
            if_pc_next_s    = pc_r;
            if_valid_next_s = 1'b1;
        end
    end

    // PC and IF/ID register; async reset clears the slot and reloads RESET_PC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r       <= RESET_PC;
            if_instr_r <= 32'h0;
            if_pc_r    <= 64'h0;
            if_valid_r <= 1'b0;
        end else begin
            pc_r       <= pc_next_s;
            if_instr_r <= if_instr_next_s;
            if_pc_r    <= if_pc_next_s;
            if_valid_r <= if_valid_next_s;
        end
    end

    assign imem_addr = pc_r;
    assign if_instr  = if_instr_r;
    assign if_pc     = if_pc_r;
    assign if_valid  = if_valid_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a combinational instruction-memory model.
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        br_taken;
    logic        br_uncond;
    logic [31:0] br_instr;
    logic [63:0] br_pc;
    logic        br_reg;
    logic [63:0] br_reg_target;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        if_valid;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(64'h0)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .br_taken      (br_taken),
        .br_uncond     (br_uncond),
        .br_instr      (br_instr),
        .br_pc         (br_pc),
        .br_reg        (br_reg),
        .br_reg_target (br_reg_target),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_valid      (if_valid)
    );

    // Memory returns 8B000000 + address so every fetch is identifiable.
    assign imem_rdata = 32'h8B00_0000 + imem_addr[31:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_slot(input string tag, input logic [63:0] pc, input logic [31:0] instr,
                              input logic valid);
        check({tag, ".if_pc"}, if_pc, pc);
        check({tag, ".if_instr"}, {32'h0, if_instr}, {32'h0, instr});
        check({tag, ".if_valid"}, {63'h0, if_valid}, {63'h0, valid});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n       = 1'b0;
        stall         = 1'b0;
        br_taken      = 1'b0;
        br_uncond     = 1'b0;
        br_instr      = 32'h0;
        br_pc         = 64'h0;
        br_reg        = 1'b0;
        br_reg_target = 64'h0;

        #2;
        check("reset.imem_addr", imem_addr, 64'h0);
        check_slot("reset", 64'h0, 32'h0, 1'b0);

        // Reset release and sequential fetch.
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check_slot("seq0", 64'h0, 32'h8B00_0000, 1'b1);
        check("seq0.imem_addr", imem_addr, 64'h4);
        step();
        check_slot("seq1", 64'h4, 32'h8B00_0004, 1'b1);
        step();
        check_slot("seq2", 64'h8, 32'h8B00_0008, 1'b1);
        step();
        check("seq3.imem_addr", imem_addr, 64'h10);

        // Stall hold for three edges at PC 0x10.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.imem_addr", imem_addr, 64'h10);
            check_slot("stall", 64'hC, 32'h8B00_000C, 1'b1);
        end
        stall = 1'b0;
        step();
        check_slot("unstall", 64'h10, 32'h8B00_0010, 1'b1);

        // Backward B branch: 0x100 + (-2 << 2) = 0xF8.
        br_taken  = 1'b1;
        br_uncond = 1'b1;
        br_instr  = 32'h03FF_FFFE;
        br_pc     = 64'h100;
        step();
        check("bwd_b.imem_addr", imem_addr, 64'hF8);
        check_slot("bwd_b.bubble", 64'h10, 32'h0, 1'b0);
        br_taken = 1'b0;
        step();
        check_slot("bwd_b.target", 64'hF8, 32'h8B00_00F8, 1'b1);

        // Forward CB branch: 0x40 + (5 << 2) = 0x54.
        br_taken  = 1'b1;
        br_uncond = 1'b0;
        br_instr  = 32'h0000_00A0;
        br_pc     = 64'h40;
        step();
        check("fwd_cb.imem_addr", imem_addr, 64'h54);
        check("fwd_cb.if_valid", {63'h0, if_valid}, 64'h0);

        // Backward CB branch: offset -1 sign-extended from bit 23 gives 0x3C.
        br_instr = 32'h00FF_FFE0;
        step();
        check("bwd_cb.imem_addr", imem_addr, 64'h3C);
        br_taken = 1'b0;
        step();
        check_slot("bwd_cb.target", 64'h3C, 32'h8B00_003C, 1'b1);

        // BR to the top word, then sequential wrap to 0.
        br_reg        = 1'b1;
        br_reg_target = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        check("wrap.br_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        br_reg = 1'b0;
        step();
        check("wrap.imem_addr", imem_addr, 64'h0);
        check_slot("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 32'h8AFF_FFFC, 1'b1);

        // Simultaneous BR, B and stall: BR wins, stall is overridden.
        br_reg        = 1'b1;
        br_reg_target = 64'h203;
        br_taken      = 1'b1;
        br_uncond     = 1'b1;
        br_instr      = 32'h03FF_FFFE;
        br_pc         = 64'h100;
        stall         = 1'b1;
        step();
        check("simul.imem_addr", imem_addr, 64'h200);
        check_slot("simul.bubble", 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 1'b0);
        br_reg   = 1'b0;
        br_taken = 1'b0;
        stall    = 1'b0;
        step();
        check_slot("simul.target", 64'h200, 32'h8B00_0200, 1'b1);

        // Reach PC 0x80 with a live slot, then assert reset between edges.
        br_reg        = 1'b1;
        br_reg_target = 64'h7C;
        step();
        br_reg = 1'b0;
        step();
        check("pre_rst.imem_addr", imem_addr, 64'h80);
        check_slot("pre_rst", 64'h7C, 32'h8B00_007C, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst.imem_addr", imem_addr, 64'h0);
        check_slot("async_rst", 64'h0, 32'h0, 1'b0);
        step();
        check_slot("rst_held", 64'h0, 32'h0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check_slot("rst_release", 64'h0, 32'h8B00_0000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
